// File: rtl/time_base_capture.sv
// Reference-tick synchroniser and glitch filter, runtime prescaler, CW-bit timestamp
// with sticky wrap flag, plus NCH capture channels with valid/ack handshake.
module time_base_capture #(
  parameter int CW        = 32,
  parameter int PW        = 16,
  parameter int DIV_SHIFT = 2,
  parameter int NCH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk12,
  input  logic              clr,
  input  logic              en,
  input  logic [PW-1:0]     nbuf,
  input  logic [1:0]        edge_mode,
  input  logic [NCH-1:0]    cap_stb,
  input  logic [NCH-1:0]    cap_ack,
  output logic [CW-1:0]     q,
  output logic              tick_out,
  output logic              ovf,
  output logic [NCH*CW-1:0] cap_data,
  output logic [NCH-1:0]    cap_valid,
  output logic [NCH-1:0]    cap_ovr
);

  logic [3:0]        r_frnt;
  logic [PW-1:0]     r_div;
  logic [PW-1:0]     r_sch;
  logic              r_clr_f;
  logic [CW-1:0]     r_q;
  logic              r_tick;
  logic              r_ovf;
  logic [NCH*CW-1:0] r_cap_data;
  logic [NCH-1:0]    r_cap_valid;
  logic [NCH-1:0]    r_cap_ovr;

  logic w_rise;
  logic w_fall;
  logic w_qe;
  logic w_roll;

  // A level must be seen on two consecutive samples to qualify, so 1-clk pulses drop out.
  assign w_rise = (r_frnt[3:1] == 3'b011);
  assign w_fall = (r_frnt[3:1] == 3'b100);

  always_comb begin
    w_qe = 1'b0;
    case (edge_mode)
      2'b00:   w_qe = w_rise;
      2'b01:   w_qe = w_fall;
      2'b10:   w_qe = w_rise | w_fall;
      default: w_qe = 1'b0;
    endcase
    w_qe = w_qe & en;
  end

  // >= rather than == so a divisor lowered below the running count rolls over at once.
  assign w_roll = w_qe && (r_sch >= r_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frnt  <= '0;
      r_div   <= '0;
      r_sch   <= '0;
      r_clr_f <= 1'b0;
      r_q     <= '0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_frnt  <= {r_frnt[2:0], clk12};
      r_div   <= nbuf >> DIV_SHIFT;
      r_clr_f <= clr;
      if (r_clr_f) begin
        r_q    <= '0;
        r_sch  <= '0;
        r_ovf  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_tick <= w_roll;
        if (w_roll) begin
          r_sch <= '0;
          r_q   <= r_q + 1'b1;
          if (&r_q) r_ovf <= 1'b1;
        end else if (w_qe) begin
          r_sch <= r_sch + 1'b1;
        end
      end
    end
  end

  // Capture samples the registered q, i.e. the value before any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_data  <= '0;
      r_cap_valid <= '0;
      r_cap_ovr   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cap_stb[i]) begin
          r_cap_data[i*CW +: CW] <= r_q;
          r_cap_valid[i]         <= 1'b1;
          if (r_cap_valid[i] && !cap_ack[i]) r_cap_ovr[i] <= 1'b1;
        end else if (cap_ack[i]) begin
          r_cap_valid[i] <= 1'b0;
        end
      end
      if (r_clr_f) r_cap_ovr <= '0;
    end
  end

  assign q         = r_q;
  assign tick_out  = r_tick;
  assign ovf       = r_ovf;
  assign cap_data  = r_cap_data;
  assign cap_valid = r_cap_valid;
  assign cap_ovr   = r_cap_ovr;

endmodule

// File: tb/tb_time_base_capture.sv
// Bench for time_base_capture: directed sequences, a capture handshake table and
// randomized traffic, all checked every cycle against a behavioural model.
module tb_time_base_capture;
  localparam int CW = 8;
  localparam int PW = 16;
  localparam int DS = 2;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst, clk12, clr, en;
  logic [PW-1:0] nbuf;
  logic [1:0] edge_mode;
  logic [NCH-1:0] cap_stb, cap_ack;
  logic [CW-1:0] q;
  logic tick_out, ovf;
  logic [NCH*CW-1:0] cap_data;
  logic [NCH-1:0] cap_valid, cap_ovr;

  always #5 clk = ~clk;

  time_base_capture #(.CW(CW), .PW(PW), .DIV_SHIFT(DS), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .clk12(clk12), .clr(clr), .en(en), .nbuf(nbuf),
    .edge_mode(edge_mode), .cap_stb(cap_stb), .cap_ack(cap_ack), .q(q),
    .tick_out(tick_out), .ovf(ovf), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ovr(cap_ovr)
  );

  int total = 0;
  int bad = 0;
  int ticks = 0;

  // behavioural model state
  int m_q, m_sch, m_div;
  bit m_tick, m_ovf, m_clrf;
  logic [NCH-1:0] m_val, m_ovr;
  int m_cd [NCH];
  bit smp[$] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the model, from the inputs as they stood at the edge.
  task automatic model_step();
    bit r, f, qe;
    if (rst) begin
      m_q = 0; m_sch = 0; m_div = 0; m_tick = 0; m_ovf = 0; m_clrf = 0;
      m_val = '0; m_ovr = '0;
      for (int i = 0; i < NCH; i++) m_cd[i] = 0;
      smp = '{0, 0, 0, 0};
    end else begin
      r = !smp[0] && smp[1] && smp[2];
      f = smp[0] && !smp[1] && !smp[2];
      case (edge_mode)
        2'd0: qe = r;
        2'd1: qe = f;
        2'd2: qe = r || f;
        default: qe = 0;
      endcase
      qe = qe && en;
      for (int i = 0; i < NCH; i++) begin
        if (cap_stb[i]) begin
          if (m_val[i] && !cap_ack[i]) m_ovr[i] = 1'b1;
          m_cd[i] = m_q;
          m_val[i] = 1'b1;
        end else if (cap_ack[i]) begin
          m_val[i] = 1'b0;
        end
      end
      if (m_clrf) begin
        m_q = 0; m_sch = 0; m_ovf = 0; m_tick = 0; m_ovr = '0;
      end else begin
        m_tick = 0;
        if (qe) begin
          if (m_sch >= m_div) begin
            m_sch = 0;
            m_tick = 1;
            m_q = m_q + 1;
            if (m_q == (1 << CW)) begin
              m_q = 0;
              m_ovf = 1;
            end
          end else begin
            m_sch = m_sch + 1;
          end
        end
      end
      m_div = int'(nbuf) >> DS;
      m_clrf = clr;
      void'(smp.pop_front());
      smp.push_back(clk12);
    end
  endtask

  task automatic cyc(input int n);
    logic [NCH*CW-1:0] ed;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NCH; i++) ed[i*CW +: CW] = m_cd[i][CW-1:0];
      if (tick_out === 1'b1) ticks++;
      chk("q", q, m_q);
      chk("tick_out", tick_out, m_tick);
      chk("ovf", ovf, m_ovf);
      chk("cap_valid", cap_valid, m_val);
      chk("cap_ovr", cap_ovr, m_ovr);
      chk("cap_data", cap_data, ed);
    end
  endtask

  task automatic pulse();
    clk12 = 1'b1; cyc(3);
    clk12 = 1'b0; cyc(3);
  endtask

  task automatic fast_edges(input int n);
    for (int k = 0; k < n; k++) begin
      clk12 = 1'b1; cyc(2);
      clk12 = 1'b0; cyc(2);
    end
  endtask

  typedef struct {
    int edges;
    logic [NCH-1:0] stb;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] ev;
    logic [NCH-1:0] eo;
    int ch;
    int ed;
  } cvec_t;

  cvec_t tbl [9];

  initial begin
    tbl[0] = '{0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 7};
    tbl[1] = '{2, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 9};
    tbl[2] = '{0, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 9};
    tbl[3] = '{0, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 1, 9};
    tbl[4] = '{0, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 1, 9};
    tbl[5] = '{0, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 2, 0};
    tbl[6] = '{1, 4'b1100, 4'b0000, 4'b1100, 4'b0001, 3, 10};
    tbl[7] = '{0, 4'b0100, 4'b0100, 4'b1100, 4'b0001, 2, 10};
    tbl[8] = '{1, 4'b1000, 4'b0000, 4'b1100, 4'b1001, 3, 11};

    rst = 1'b1; clk12 = 1'b0; clr = 1'b0; en = 1'b0; nbuf = '0;
    edge_mode = 2'b00; cap_stb = '0; cap_ack = '0;
    cyc(1);
    chk("reset_q", q, 0);
    chk("reset_flags", {tick_out, ovf, cap_valid, cap_ovr}, 0);
    chk("reset_data", cap_data, 0);
    cyc(1);
    rst = 1'b0;

    // divide by 5: 20 slow rising edges
    nbuf = 16; en = 1'b1; edge_mode = 2'b00;
    cyc(2);
    ticks = 0;
    for (int e = 1; e <= 20; e++) begin
      clk12 = 1'b1;
      if (e % 5 == 0) begin
        cyc(3); chk("div_before", q, e / 5 - 1);
        cyc(1); chk("div_after", q, e / 5);
        cyc(4);
      end else begin
        cyc(8);
      end
      clk12 = 1'b0; cyc(8);
    end
    chk("div_q", q, 4);
    chk("div_ticks", ticks, 4);

    // both-edge mode, disabled mode, glitch rejection
    nbuf = 0; edge_mode = 2'b10; cyc(2);
    for (int p = 0; p < 5; p++) begin
      clk12 = 1'b1; cyc(4);
      clk12 = 1'b0; cyc(4);
    end
    cyc(2);
    chk("both_q", q, 14);
    edge_mode = 2'b11;
    for (int p = 0; p < 3; p++) begin
      clk12 = 1'b1; cyc(4);
      clk12 = 1'b0; cyc(4);
    end
    chk("off_q", q, 14);
    edge_mode = 2'b00;
    for (int p = 0; p < 3; p++) begin
      clk12 = 1'b1; cyc(1);
      clk12 = 1'b0; cyc(4);
    end
    chk("glitch_rise_q", q, 14);
    edge_mode = 2'b01; clk12 = 1'b1; cyc(6);
    for (int p = 0; p < 3; p++) begin
      clk12 = 1'b0; cyc(1);
      clk12 = 1'b1; cyc(4);
    end
    chk("glitch_fall_q", q, 14);
    edge_mode = 2'b11; clk12 = 1'b0; cyc(6);
    chk("mode_restore_q", q, 14);

    // reset in the middle of a count with a capture pending
    edge_mode = 2'b00;
    cap_stb = 4'b1000; cyc(1); cap_stb = '0;
    chk("pre_rst_valid", cap_valid, 4'b1000);
    rst = 1'b1; cyc(1);
    chk("rst_q", q, 0);
    chk("rst_flags", {tick_out, ovf, cap_valid, cap_ovr}, 0);
    chk("rst_data", cap_data, 0);
    cyc(1); rst = 1'b0;
    pulse(); pulse();
    chk("restart_q", q, 2);

    // capture handshake table starting at q=7
    repeat (5) pulse();
    chk("cap_start_q", q, 7);
    for (int k = 0; k < 9; k++) begin
      repeat (tbl[k].edges) pulse();
      cap_stb = tbl[k].stb; cap_ack = tbl[k].ack;
      cyc(1);
      cap_stb = '0; cap_ack = '0;
      chk($sformatf("cap%0d_valid", k), cap_valid, tbl[k].ev);
      chk($sformatf("cap%0d_ovr", k), cap_ovr, tbl[k].eo);
      chk($sformatf("cap%0d_data", k), cap_data[tbl[k].ch*CW +: CW], tbl[k].ed);
    end

    // lowering the divisor below the running count
    nbuf = 40; cyc(2);
    repeat (3) pulse();
    chk("div40_q", q, 11);
    nbuf = 8; cyc(2);
    pulse();
    chk("div_drop_q", q, 12);
    repeat (2) pulse();
    chk("div8_hold_q", q, 12);
    pulse();
    chk("div8_roll_q", q, 13);

    // clear, wrap, and a qualified edge coincident with the registered clear
    nbuf = 0; cyc(2);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clr_wait_q", q, 13);
    cyc(1);
    chk("clr_q", q, 0);
    chk("clr_valid_kept", cap_valid, 4'b1100);
    chk("clr_ovr", cap_ovr, 0);
    fast_edges(255);
    chk("pre_wrap_q", q, 255);
    chk("pre_wrap_ovf", ovf, 0);
    fast_edges(1);
    chk("wrap_q", q, 0);
    chk("wrap_ovf", ovf, 1);
    fast_edges(2);
    chk("post_wrap_q", q, 2);
    clk12 = 1'b1; cyc(2);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("coinc_wait_q", q, 2);
    chk("coinc_wait_ovf", ovf, 1);
    cyc(1);
    chk("coinc_q", q, 0);
    chk("coinc_ovf", ovf, 0);
    clk12 = 1'b0; cyc(6);
    chk("coinc_dropped_q", q, 0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) clk12 = ~clk12;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) nbuf = 16'($urandom_range(0, 15));
      cap_stb = 4'($urandom & $urandom & $urandom);
      cap_ack = 4'($urandom & $urandom);
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    rst = 1'b0; clr = 1'b0; cap_stb = '0; cap_ack = '0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
